// File: rtl/proc_mem_responder_pkg.sv
// proc_mem_pkg: shared types and constants for the processor memory responder.
// Holds the loader FSM state enum, RAM geometry and the host_sel encodings
// used by the interface, the RAM macro and the responder top level.
package proc_mem_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2 ** ADDR_W;

  // host_sel encodings, sampled on the first byte of a load session
  localparam logic PROG_SEL = 1'b0;
  localparam logic DATA_SEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WRITE,
    DONE
  } load_state_t;

  // The host may offer a byte in every state that waits for one.
  function automatic logic accepts_bytes(input load_state_t s);
    return (s == IDLE) || (s == LO) || (s == HI);
  endfunction

endpackage

// File: rtl/proc_mem_responder_if.sv
// proc_mem_if: bundle of the core-side memory bus and the host byte-load port.
//   Core side : pc / prog_ram_read_en -> instr_out (instruction fetch)
//               data_ram_addr / data_ram_read_en / write_ram_en / data_ram_din
//               -> data_ram_dout (data load/store)
//   Host side : host_valid / host_byte / host_sel / host_last, host_ready back
//   Status    : busy, load_done, start, load_ovf
// master = core + host driver, slave = the memory responder.
interface proc_mem_if;
  import proc_mem_pkg::*;

  logic [ADDR_W-1:0] pc;
  logic              prog_ram_read_en;
  logic [DATA_W-1:0] instr_out;

  logic              data_ram_read_en;
  logic              write_ram_en;
  logic [ADDR_W-1:0] data_ram_addr;
  logic [DATA_W-1:0] data_ram_din;
  logic [DATA_W-1:0] data_ram_dout;

  logic              host_valid;
  logic [7:0]        host_byte;
  logic              host_sel;
  logic              host_last;
  logic              host_ready;

  logic              busy;
  logic              load_done;
  logic              start;
  logic              load_ovf;

  modport master (
    output pc, prog_ram_read_en, data_ram_read_en, write_ram_en,
           data_ram_addr, data_ram_din, host_valid, host_byte, host_sel,
           host_last,
    input  instr_out, data_ram_dout, host_ready, busy, load_done, start,
           load_ovf
  );

  modport slave (
    input  pc, prog_ram_read_en, data_ram_read_en, write_ram_en,
           data_ram_addr, data_ram_din, host_valid, host_byte, host_sel,
           host_last,
    output instr_out, data_ram_dout, host_ready, busy, load_done, start,
           load_ovf
  );

endinterface

// File: rtl/proc_mem_responder_ram.sv
// ram_16x128: synchronous RAM, one write port and one registered read port.
//   clk, rst_n        : clock and synchronous active-low reset (read register only)
//   we, waddr, wdata  : write port, takes effect at the rising edge
//   re, raddr, rdata  : read port; rdata updates one edge after re, else holds
// A same-address read and write in one cycle returns the old word.
module ram_16x128
  import proc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never reset so a loaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read sees the pre-write contents: read-before-write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/proc_mem_responder.sv
// proc_mem_responder: owns the program and data RAMs of the 16-bit core.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : proc_mem_if.slave carrying core fetch/load/store, the host
//                byte-load port and the load status flags
// The host fills either RAM two bytes per word (low byte first). While a
// session is in progress the core side is locked out and the host is the only
// writer. A completed program-RAM session pulses start to the core.
module proc_mem_responder
  import proc_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  proc_mem_if.slave  bus
);

  load_state_t       state;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        lo_byte;
  logic [7:0]        hi_byte;
  logic              sel_q;
  logic              last_q;
  logic              host_ready_q;
  logic              busy_q;
  logic              load_done_q;
  logic              start_q;
  logic              load_ovf_q;

  logic              accept;
  logic              host_wr;
  logic [DATA_W-1:0] host_word;

  logic              prog_we;
  logic              prog_re;
  logic [DATA_W-1:0] prog_rdata;
  logic              data_we;
  logic [ADDR_W-1:0] data_waddr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_re;
  logic [DATA_W-1:0] data_rdata;

  assign accept    = bus.host_valid && host_ready_q;
  assign host_wr   = rst_n && (state == WRITE);
  assign host_word = {hi_byte, lo_byte};

  // Loader FSM. host_ready is registered and follows the state being entered,
  // so it is 0 in the first cycle after reset and during WRITE/DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      load_addr    <= '0;
      lo_byte      <= '0;
      hi_byte      <= '0;
      sel_q        <= PROG_SEL;
      last_q       <= 1'b0;
      host_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      start_q      <= 1'b0;
      load_ovf_q   <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      start_q     <= 1'b0;
      case (state)
        IDLE: begin
          host_ready_q <= accepts_bytes(IDLE);
          load_addr    <= '0;
          if (accept) begin
            lo_byte    <= bus.host_byte;
            sel_q      <= bus.host_sel;
            busy_q     <= 1'b1;
            load_ovf_q <= 1'b0;
            state      <= HI;
          end
        end
        LO: begin
          if (accept) begin
            lo_byte <= bus.host_byte;
            state   <= HI;
          end
        end
        HI: begin
          if (accept) begin
            hi_byte      <= bus.host_byte;
            last_q       <= bus.host_last;
            host_ready_q <= accepts_bytes(WRITE);
            state        <= WRITE;
          end
        end
        WRITE: begin
          load_addr <= load_addr + ADDR_W'(1);
          // Natural 7-bit wrap past the last word flags an overflow.
          if (load_addr == ADDR_W'(DEPTH - 1)) begin
            load_ovf_q <= 1'b1;
          end
          if (last_q) begin
            load_done_q  <= 1'b1;
            start_q      <= (sel_q == PROG_SEL);
            host_ready_q <= accepts_bytes(DONE);
            state        <= DONE;
          end else begin
            host_ready_q <= accepts_bytes(LO);
            state        <= LO;
          end
        end
        DONE: begin
          busy_q       <= 1'b0;
          load_addr    <= '0;
          host_ready_q <= accepts_bytes(IDLE);
          state        <= IDLE;
        end
        default: begin
          host_ready_q <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Write-port muxing: the host owns both RAMs while busy, the core owns the
  // data RAM otherwise. Core reads are suppressed while busy so outputs hold.
  always_comb begin
    prog_we    = host_wr && (sel_q == PROG_SEL);
    prog_re    = bus.prog_ram_read_en && !busy_q;
    data_re    = bus.data_ram_read_en && !busy_q;
    data_we    = 1'b0;
    data_waddr = bus.data_ram_addr;
    data_wdata = bus.data_ram_din;
    if (busy_q) begin
      data_we    = host_wr && (sel_q == DATA_SEL);
      data_waddr = load_addr;
      data_wdata = host_word;
    end else begin
      data_we    = rst_n && bus.write_ram_en;
    end
  end

  ram_16x128 u_prog_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (prog_we),
    .waddr (load_addr),
    .wdata (host_word),
    .re    (prog_re),
    .raddr (bus.pc),
    .rdata (prog_rdata)
  );

  ram_16x128 u_data_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (data_we),
    .waddr (data_waddr),
    .wdata (data_wdata),
    .re    (data_re),
    .raddr (bus.data_ram_addr),
    .rdata (data_rdata)
  );

  assign bus.instr_out     = prog_rdata;
  assign bus.data_ram_dout = data_rdata;
  assign bus.host_ready    = host_ready_q;
  assign bus.busy          = busy_q;
  assign bus.load_done     = load_done_q;
  assign bus.start         = start_q;
  assign bus.load_ovf      = load_ovf_q;

endmodule

// File: tb/tb_proc_mem_responder.sv
// tb_proc_mem_responder: directed + randomized bench for proc_mem_responder.
// A word-level model (two arrays plus session rules) predicts RAM contents,
// pulses and the overflow flag; DUT outputs are sampled 1 time unit after
// each rising edge.
module tb_proc_mem_responder;
  import proc_mem_pkg::*;

  logic clk;
  logic rst_n;
  proc_mem_if bus ();

  proc_mem_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] prog_m [DEPTH];
  logic [DATA_W-1:0] data_m [DEPTH];
  logic [DATA_W-1:0] wq [$];
  logic [DATA_W-1:0] exp_instr;
  logic [DATA_W-1:0] exp_dout;
  logic [DATA_W-1:0] rd;

  int done_cnt    = 0;
  int start_cnt   = 0;
  int start_alone = 0;

  // Pulse monitor: counts load_done/start cycles and start without load_done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.load_done) done_cnt++;
      if (bus.start) start_cnt++;
      if (bus.start && !bus.load_done) start_alone++;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle of core-side strobes, then all strobes drop.
  task automatic applyStimulus(input logic fetch, input logic [ADDR_W-1:0] pc,
                               input logic load, input logic store,
                               input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] din);
    bus.prog_ram_read_en = fetch;
    bus.pc               = pc;
    bus.data_ram_read_en = load;
    bus.write_ram_en     = store;
    bus.data_ram_addr    = addr;
    bus.data_ram_din     = din;
    tick();
    bus.prog_ram_read_en = 1'b0;
    bus.data_ram_read_en = 1'b0;
    bus.write_ram_en     = 1'b0;
  endtask

  task automatic readProg(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    applyStimulus(1'b1, a, 1'b0, 1'b0, '0, '0);
    d = bus.instr_out;
    exp_instr = prog_m[a];
  endtask

  task automatic readData(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, a, '0);
    d = bus.data_ram_dout;
    exp_dout = data_m[a];
  endtask

  // Offers one byte and waits (bounded) until it is accepted. host_valid is
  // left high so back-to-back bytes stay asserted across WRITE cycles.
  task automatic sendByte(input logic [7:0] b, input logic sel, input logic last);
    int waited = 0;
    bus.host_valid = 1'b1;
    bus.host_byte  = b;
    bus.host_sel   = sel;
    bus.host_last  = last;
    while (bus.host_ready !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput("host_ready_wait", {31'd0, bus.host_ready}, 32'd1);
    tick();
  endtask

  // Sends every word in wq as one session and checks the end-of-session pulses.
  task automatic loadSession(input logic sel);
    int n = wq.size();
    logic [DATA_W-1:0] w;
    logic exp_ovf;
    for (int i = 0; i < n; i++) begin
      w = wq[i];
      sendByte(w[7:0], sel, 1'b0);
      sendByte(w[15:8], sel, (i == n - 1));
    end
    bus.host_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (sel == PROG_SEL) prog_m[i % DEPTH] = wq[i];
      else data_m[i % DEPTH] = wq[i];
    end
    exp_ovf = (n >= DEPTH);
    tick();
    checkOutput("done_pulse", {31'd0, bus.load_done}, 32'd1);
    checkOutput("start_pulse", {31'd0, bus.start}, {31'd0, sel == PROG_SEL});
    checkOutput("busy_in_done", {31'd0, bus.busy}, 32'd1);
    checkOutput("ovf_at_done", {31'd0, bus.load_ovf}, {31'd0, exp_ovf});
    tick();
    checkOutput("busy_after_done", {31'd0, bus.busy}, 32'd0);
    checkOutput("done_cleared", {31'd0, bus.load_done}, 32'd0);
  endtask

  initial begin
    bus.pc = '0; bus.prog_ram_read_en = 1'b0;
    bus.data_ram_read_en = 1'b0; bus.write_ram_en = 1'b0;
    bus.data_ram_addr = '0; bus.data_ram_din = '0;
    bus.host_valid = 1'b0; bus.host_byte = '0; bus.host_sel = 1'b0;
    bus.host_last = 1'b0;
    rst_n = 1'b0;
    exp_instr = '0;
    exp_dout  = '0;

    // Reset values
    repeat (3) tick();
    checkOutput("rst_instr_out", {16'd0, bus.instr_out}, 32'd0);
    checkOutput("rst_data_dout", {16'd0, bus.data_ram_dout}, 32'd0);
    checkOutput("rst_host_ready", {31'd0, bus.host_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_load_done", {31'd0, bus.load_done}, 32'd0);
    checkOutput("rst_start", {31'd0, bus.start}, 32'd0);
    checkOutput("rst_load_ovf", {31'd0, bus.load_ovf}, 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("ready_after_release", {31'd0, bus.host_ready}, 32'd1);

    // Program load of three words
    wq = '{16'h1234, 16'hABCD, 16'h00FF};
    loadSession(PROG_SEL);
    checkOutput("done_count_1", done_cnt, 1);
    checkOutput("start_count_1", start_cnt, 1);
    checkOutput("start_alone", start_alone, 0);
    readProg(7'd1, rd);
    checkOutput("fetch_pc1", {16'd0, rd}, {16'd0, prog_m[1]});
    readProg(7'd0, rd);
    checkOutput("fetch_pc0", {16'd0, rd}, {16'd0, prog_m[0]});
    readProg(7'd2, rd);
    checkOutput("fetch_pc2", {16'd0, rd}, {16'd0, prog_m[2]});
    tick();
    checkOutput("instr_hold", {16'd0, bus.instr_out}, {16'd0, exp_instr});

    // Core store/load, and same-cycle read-before-write
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 7'd5, 16'hBEEF);
    data_m[5] = 16'hBEEF;
    readData(7'd5, rd);
    checkOutput("load_beef", {16'd0, rd}, 32'h0000BEEF);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 7'd5, 16'h1111);
    checkOutput("rbw_old_word", {16'd0, bus.data_ram_dout}, {16'd0, data_m[5]});
    data_m[5] = 16'h1111;
    readData(7'd5, rd);
    checkOutput("rbw_new_word", {16'd0, rd}, {16'd0, data_m[5]});
    repeat (2) tick();
    checkOutput("dout_hold", {16'd0, bus.data_ram_dout}, {16'd0, exp_dout});

    // Randomized data-RAM host session: no start pulse
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(16'($urandom()));
    loadSession(DATA_SEL);
    checkOutput("done_count_2", done_cnt, 2);
    checkOutput("start_count_2", start_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      readData(7'(i), rd);
      checkOutput("data_session_word", {16'd0, rd}, {16'd0, data_m[i]});
    end
    readData(7'd5, rd);
    checkOutput("data5_untouched", {16'd0, rd}, {16'd0, data_m[5]});

    // Wrap: 129 random words into program RAM
    wq.delete();
    for (int i = 0; i <= DEPTH; i++) wq.push_back(16'($urandom()));
    loadSession(PROG_SEL);
    checkOutput("ovf_sticky", {31'd0, bus.load_ovf}, 32'd1);
    checkOutput("start_count_3", start_cnt, 2);
    readProg(7'd0, rd);
    checkOutput("wrap_pc0", {16'd0, rd}, {16'd0, prog_m[0]});
    readProg(7'd1, rd);
    checkOutput("wrap_pc1", {16'd0, rd}, {16'd0, prog_m[1]});
    readProg(7'd127, rd);
    checkOutput("wrap_pc127", {16'd0, rd}, {16'd0, prog_m[127]});
    readData(7'd2, rd);
    checkOutput("pre_lock_load", {16'd0, rd}, {16'd0, data_m[2]});

    // Next session clears load_ovf; core accesses are locked out while busy
    sendByte(8'h3C, DATA_SEL, 1'b0);
    bus.host_valid = 1'b0;
    checkOutput("ovf_cleared", {31'd0, bus.load_ovf}, 32'd0);
    checkOutput("busy_in_session", {31'd0, bus.busy}, 32'd1);
    applyStimulus(1'b1, 7'd0, 1'b1, 1'b1, 7'd3, 16'h5555);
    checkOutput("lock_dout_hold", {16'd0, bus.data_ram_dout}, {16'd0, exp_dout});
    checkOutput("lock_instr_hold", {16'd0, bus.instr_out}, {16'd0, exp_instr});
    sendByte(8'hC3, DATA_SEL, 1'b1);
    bus.host_valid = 1'b0;
    data_m[0] = 16'hC33C;
    tick();
    checkOutput("lock_done", {31'd0, bus.load_done}, 32'd1);
    tick();
    readData(7'd3, rd);
    checkOutput("lock_data3", {16'd0, rd}, {16'd0, data_m[3]});
    readData(7'd0, rd);
    checkOutput("lock_data0", {16'd0, rd}, 32'h0000C33C);

    // Reset mid-load discards the partial word
    sendByte(8'h77, PROG_SEL, 1'b0);
    bus.host_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midrst_ready", {31'd0, bus.host_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_ready_back", {31'd0, bus.host_ready}, 32'd1);
    readProg(7'd0, rd);
    checkOutput("midrst_no_write", {16'd0, rd}, {16'd0, prog_m[0]});
    wq = '{16'h5A5A};
    loadSession(PROG_SEL);
    readProg(7'd0, rd);
    checkOutput("post_rst_addr0", {16'd0, rd}, 32'h00005A5A);
    readProg(7'd1, rd);
    checkOutput("post_rst_addr1", {16'd0, rd}, {16'd0, prog_m[1]});
    checkOutput("start_count_4", start_cnt, 3);
    checkOutput("start_alone_end", start_alone, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
